// File: rtl/ci_dotp_master.sv
// ---------------------------------------------------------------------------
// ci_dotp_master
//   Streams signed 32-bit operand pairs into a custom-instruction (CI) MAC
//   slave and reads back the 64-bit accumulated dot product.
//   Per pair: one MAC issue (n=1 for the first pair of a vector, n=2 after).
//   After the last pair: read the low word (n=3), then the high word (n=4).
//
// Parameters
//   TIMEOUT      max wait cycles for ci_done (only with CIM_TIMEOUT_EN)
//
// Build option
//   CIM_TIMEOUT_EN  when defined, a watchdog aborts a wait state after
//                   TIMEOUT cycles without ci_done and returns an error result.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/ready         operand pair handshake (cmd_a, cmd_b, cmd_last)
//   res_valid/ready         result handshake (res_data = {hi,lo}, res_err)
//   ci_clk_en, ci_start     CI clock enable, one-cycle start pulse
//   ci_n, ci_dataa/datab    CI opcode and operands, held until ci_done
//   ci_done, ci_result      CI completion and read data
// ---------------------------------------------------------------------------
module ci_dotp_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic        cmd_last,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        res_err,
   output logic        ci_clk_en,
   output logic        ci_start,
   output logic [7:0]  ci_n,
   output logic [31:0] ci_dataa,
   output logic [31:0] ci_datab,
   input  logic        ci_done,
   input  logic [31:0] ci_result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC  = 3'd1;
   localparam logic [2:0] S_WMAC = 3'd2;
   localparam logic [2:0] S_RLO  = 3'd3;
   localparam logic [2:0] S_WLO  = 3'd4;
   localparam logic [2:0] S_RHI  = 3'd5;
   localparam logic [2:0] S_WHI  = 3'd6;
   localparam logic [2:0] S_OUT  = 3'd7;

   localparam logic [7:0] N_MAC_FIRST = 8'd1;
   localparam logic [7:0] N_MAC_ACC   = 8'd2;
   localparam logic [7:0] N_RD_LO     = 8'd3;
   localparam logic [7:0] N_RD_HI     = 8'd4;

   logic [2:0]  state_q, state_d;
   logic        first_q, first_d;
   logic        last_q, last_d;
   logic [7:0]  n_q, n_d;
   logic [31:0] dataa_q, dataa_d;
   logic [31:0] datab_q, datab_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        ready_q;
   logic        clk_en_q;

`ifdef CIM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          in_wait;

   assign in_wait = (state_q == S_WMAC) || (state_q == S_WLO) || (state_q == S_WHI);
`endif

   always_comb begin
      state_d = state_q;
      first_d = first_q;
      last_d  = last_q;
      n_d     = n_q;
      dataa_d = dataa_q;
      datab_d = datab_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
`ifdef CIM_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = err_q;
`endif
      // Opcode and operands are loaded on the transition into an issue
      // state so they are already stable in the start cycle.
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               dataa_d = cmd_a;
               datab_d = cmd_b;
               last_d  = cmd_last;
               n_d     = first_q ? N_MAC_FIRST : N_MAC_ACC;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            first_d = 1'b0;
            state_d = S_WMAC;
         end
         S_WMAC: begin
            if (ci_done) begin
               if (last_q) begin
                  n_d     = N_RD_LO;
                  dataa_d = '0;
                  datab_d = '0;
                  state_d = S_RLO;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_RLO: state_d = S_WLO;
         S_WLO: begin
            if (ci_done) begin
               lo_d    = ci_result;
               n_d     = N_RD_HI;
               state_d = S_RHI;
            end
         end
         S_RHI: state_d = S_WHI;
         S_WHI: begin
            if (ci_done) begin
               hi_d    = ci_result;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               first_d = 1'b1;
               state_d = S_IDLE;
`ifdef CIM_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef CIM_TIMEOUT_EN
      // Watchdog: counts consecutive wait cycles without ci_done; the
      // counter falls back to zero whenever the FSM leaves a wait state.
      if (in_wait && !ci_done) begin
         if (cnt_q == CW'(TIMEOUT - 1)) begin
            lo_d    = '0;
            hi_d    = '0;
            err_d   = 1'b1;
            state_d = S_OUT;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         first_q  <= 1'b1;
         last_q   <= 1'b0;
         n_q      <= '0;
         dataa_q  <= '0;
         datab_q  <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         ready_q  <= 1'b0;
         clk_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         last_q   <= last_d;
         n_q      <= n_d;
         dataa_q  <= dataa_d;
         datab_q  <= datab_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         // Registered from the next state so it stays low through reset
         // and rises on the first clock after release.
         ready_q  <= (state_d == S_IDLE);
         clk_en_q <= 1'b1;
      end
   end

`ifdef CIM_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign res_err = err_q;
`else
   // Watchdog compiled out: error flag is constant low (TIMEOUT is never
   // negative).
   assign res_err = (TIMEOUT < 0);
`endif

   assign cmd_ready = ready_q;
   assign res_valid = (state_q == S_OUT);
   assign res_data  = {hi_q, lo_q};
   assign ci_clk_en = clk_en_q;
   assign ci_start  = (state_q == S_MAC) || (state_q == S_RLO) || (state_q == S_RHI);
   assign ci_n      = n_q;
   assign ci_dataa  = dataa_q;
   assign ci_datab  = datab_q;

endmodule

// File: tb/tb_ci_dotp_master.sv
// ---------------------------------------------------------------------------
// tb_ci_dotp_master
//   Self-checking bench for ci_dotp_master. A behavioural CI slave
//   accumulates signed products and answers a configurable number of cycles
//   after each start pulse. Table-driven dot-product vectors plus directed
//   sequences for hold-off, spurious ci_done, reset mid-read and (when
//   CIM_TIMEOUT_EN is defined) the watchdog.
// ---------------------------------------------------------------------------
module tb_ci_dotp_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_last;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic        res_err;
   logic        ci_clk_en;
   logic        ci_start;
   logic [7:0]  ci_n;
   logic [31:0] ci_dataa;
   logic [31:0] ci_datab;
   logic        ci_done;
   logic [31:0] ci_result = '0;

   logic slave_done    = 1'b0;
   logic spur_done     = 1'b0;
   logic spur_idle     = 1'b0;
   logic spur_on_start = 1'b0;
   logic slave_en      = 1'b1;
   int   slave_lat     = 1;

   int total_checks = 0;
   int pass_checks  = 0;

   logic [7:0] nq[$];

   assign ci_done = slave_done | spur_done | spur_idle;

   always #5 clk = ~clk;

   ci_dotp_master #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_last  (cmd_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_err   (res_err),
      .ci_clk_en (ci_clk_en),
      .ci_start  (ci_start),
      .ci_n      (ci_n),
      .ci_dataa  (ci_dataa),
      .ci_datab  (ci_datab),
      .ci_done   (ci_done),
      .ci_result (ci_result)
   );

   typedef struct {
      int               npairs;
      logic [2:0][31:0] a;
      logic [2:0][31:0] b;
      logic [63:0]      exp;
   } vec_t;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         pass_checks++;
   endfunction

   function automatic vec_t mk(input int np,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [31:0] a2, input logic [31:0] b2,
                               input logic [63:0] e);
      vec_t v;
      v.npairs = np;
      v.a[0] = a0; v.b[0] = b0;
      v.a[1] = a1; v.b[1] = b1;
      v.a[2] = a2; v.b[2] = b2;
      v.exp = e;
      return v;
   endfunction

   // Expected opcode for the i-th issue of a vector with np pairs.
   function automatic logic [7:0] exp_n(input int i, input int np);
      if (i == 0)       return 8'd1;
      else if (i < np)  return 8'd2;
      else if (i == np) return 8'd3;
      else              return 8'd4;
   endfunction

   // Behavioural CI slave: answers slave_lat cycles after a start pulse.
   initial begin
      int         s_cnt;
      logic [7:0] s_n;
      logic [31:0] s_a, s_b;
      longint     acc;
      s_cnt = 0; s_n = '0; s_a = '0; s_b = '0; acc = 0;
      forever begin
         @(negedge clk);
         slave_done = 1'b0;
         if (reset) begin
            s_cnt = 0;
         end else begin
            if (s_cnt > 0) begin
               s_cnt--;
               if (s_cnt == 0) begin
                  chk("ci_hold", 64'({ci_n, ci_dataa, ci_datab} === {s_n, s_a, s_b}), 64'd1);
                  case (s_n)
                     8'd1: acc = longint'($signed(s_a)) * longint'($signed(s_b));
                     8'd2: acc = acc + longint'($signed(s_a)) * longint'($signed(s_b));
                     default: ;
                  endcase
                  ci_result = (s_n == 8'd4) ? acc[63:32] : acc[31:0];
                  slave_done = 1'b1;
               end
            end
            if (ci_start && slave_en) begin
               s_n = ci_n; s_a = ci_dataa; s_b = ci_datab;
               s_cnt = slave_lat;
            end
         end
      end
   end

   // Opcode monitor and start-cycle spurious ci_done injector.
   initial begin
      forever begin
         @(negedge clk);
         spur_done = spur_on_start && ci_start;
         if (!reset && ci_start) begin
            nq.push_back(ci_n);
            if (ci_n >= 8'd3)
               chk("rd_operands_zero", 64'({ci_dataa, ci_datab}), 64'd0);
         end
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return cmd_ready;
         1:       return res_valid;
         default: return ci_start;
      endcase
   endfunction

   // Offset 1 is the negedge right after the accepting clock edge.
   task automatic wait_sig(input int which, output int off);
      off = 1;
      while (!sig(which) && off < 200) begin
         @(negedge clk);
         off++;
      end
      if (off >= 200) begin
         total_checks++;
         $display("FAIL wait_sig%0d: got no event expected event within 200 cycles", which);
      end
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
      int n;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_last = last;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total_checks++;
         $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 100 cycles");
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctrl"}, 64'({cmd_ready, res_valid, res_err, ci_start, ci_clk_en}), 64'd0);
      chk({tag, "_res_data"}, res_data, 64'd0);
      chk({tag, "_ci_n_a"}, 64'({ci_n, ci_dataa}), 64'd0);
      chk({tag, "_ci_b"}, 64'(ci_datab), 64'd0);
   endtask

   task automatic run_vector(input vec_t v, input int hold, input int idx);
      int   off;
      logic ok;
      nq.delete();
      for (int p = 0; p < v.npairs; p++) begin
         send_pair(v.a[p], v.b[p], (p == v.npairs - 1));
         chk("start_latency", 64'(ci_start), 64'd1);
         if (p != v.npairs - 1) begin
            wait_sig(0, off);
            chk("rdy_latency", 64'(off), 64'd3);
         end
      end
      wait_sig(1, off);
      chk("res_latency", 64'(off), 64'd7);
      chk("res_data", res_data, v.exp);
      chk("res_err", 64'(res_err), 64'd0);
      chk("n_count", 64'(nq.size()), 64'(v.npairs + 2));
      for (int i = 0; i < nq.size() && i < v.npairs + 2; i++)
         chk("ci_n_seq", 64'(nq[i]), 64'(exp_n(i, v.npairs)));
      if (hold > 0) begin
         ok = 1'b1;
         // A command offered while the result waits must not be taken.
         cmd_valid = 1'b1; cmd_a = 32'h55; cmd_b = 32'h66; cmd_last = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (!res_valid || res_data !== v.exp || cmd_ready || ci_start) ok = 1'b0;
         end
         cmd_valid = 1'b0;
         chk("hold_stable", 64'(ok), 64'd1);
      end
      $display("vec %0d: pairs=%0d res_data=%h res_err=%b", idx, v.npairs, res_data, res_err);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_release", 64'({res_valid, cmd_ready}), 64'b01);
   endtask

   initial begin
      vec_t vecs[5];
      int   n;
      logic ok;

      vecs[0] = mk(1, 32'd3, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd0, 32'd0, 64'hFFFFFFFFFFFFFFF4);
      vecs[1] = mk(3, 32'd2, 32'd5, 32'd7, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                   64'h3FFFFFFF00000004);
      vecs[2] = mk(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd0, 32'd0,
                   64'hFFFFFFFF00000001);
      vecs[3] = mk(1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0,
                   64'h4000000000000000);
      vecs[4] = mk(2, 32'd100, 32'd200, 32'hFFFFFFCE, 32'd400, 32'd0, 32'd0, 64'd0);

      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_last = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      reset = 1'b0;
      #1;
      chk("rdy_at_release", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("rdy_clken_after", 64'({cmd_ready, ci_clk_en}), 64'b11);

      for (int i = 0; i < 5; i++)
         run_vector(vecs[i], 0, i);

      // Result held off for 10 cycles.
      run_vector(vecs[1], 10, 5);

      // Spurious ci_done (and stray res_ready) while idle.
      spur_idle = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      spur_idle = 1'b0; res_ready = 1'b0;
      chk("idle_spur", 64'({cmd_ready, ci_start, res_valid}), 64'b100);

      // Spurious ci_done in every start cycle of a vector.
      spur_on_start = 1'b1;
      run_vector(mk(2, 32'd4, 32'd5, 32'd6, 32'd7, 32'd0, 32'd0, 64'd62), 0, 6);
      spur_on_start = 1'b0;

      // Reset while waiting for the low word.
      send_pair(32'd5, 32'd6, 1'b1);
      n = 0;
      while (!(ci_start && ci_n == 8'd3) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_rlo", 64'(ci_n), 64'd3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_reset_outs("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (res_valid) ok = 1'b0;
      end
      chk("no_res_after_rst", 64'(ok), 64'd1);
      run_vector(mk(1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 64'd1), 0, 7);

`ifdef CIM_TIMEOUT_EN
      // Slave never answers the MAC: watchdog returns an error result.
      slave_en = 1'b0;
      send_pair(32'd3, 32'd4, 1'b1);
      wait_sig(1, n);
      chk("to_latency", 64'(n), 64'd18);
      chk("to_err", 64'(res_err), 64'd1);
      chk("to_data", res_data, 64'd0);
      $display("timeout: res_data=%h res_err=%b", res_data, res_err);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      slave_en = 1'b1;
      repeat (2) @(negedge clk);
      run_vector(mk(1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 64'd6), 0, 8);
`endif

      chk("clk_en_running", 64'(ci_clk_en), 64'd1);
      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/ci_dotp_master.md
CI_DOTP_MASTER -- requirements
Module: ci_dotp_master

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles to wait for ci_done (used only with CIM_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  operand pair valid.
REQ-005 cmd_ready  out  1  operand pair accepted when cmd_valid & cmd_ready.
REQ-006 cmd_a  in  32  signed operand A.
REQ-007 cmd_b  in  32  signed operand B.
REQ-008 cmd_last  in  1  pair is last element of vector.
REQ-009 res_valid  out  1  dot-product result valid.
REQ-010 res_ready  in  1  result consumed when res_valid & res_ready.
REQ-011 res_data  out  64  signed dot product {hi,lo}.
REQ-012 res_err  out  1  result aborted by timeout.
REQ-013 ci_clk_en  out  1  custom-instruction clock enable.
REQ-014 ci_start  out  1  custom-instruction start pulse.
REQ-015 ci_n  out  8  opcode: 1 = first MAC, 2 = accumulate MAC, 3 = read low word, 4 = read high word.
REQ-016 ci_dataa / ci_datab  out  32 each  operands to slave.
REQ-017 ci_done  in  1  slave completion.
REQ-018 ci_result  in  32  slave read data.

Function
REQ-019 FSM states: IDLE, MAC, WMAC, RLO, WLO, RHI, WHI, OUT.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a handshake latches cmd_a/cmd_b/cmd_last and moves to MAC.
REQ-021 In MAC, RLO and RHI, ci_start SHALL be 1 for exactly one cycle, then the FSM moves to WMAC/WLO/WHI respectively.
REQ-022 ci_n/ci_dataa/ci_datab SHALL be stable from the start cycle until the cycle ci_done is sampled.
REQ-023 MAC SHALL issue n=1 if first flag set, else n=2; first flag SHALL clear on issue.
REQ-024 In WMAC, on ci_done: cmd_last=1 -> RLO, else -> IDLE.
REQ-025 RLO issues n=3; WLO captures ci_result into lo on ci_done; RHI issues n=4; WHI captures ci_result into hi on ci_done -> OUT.
REQ-026 OUT: res_valid=1, res_data={hi,lo}, held until res_ready; on handshake -> IDLE, set first flag.
REQ-027 ci_done SHALL be ignored outside wait states (WMAC/WLO/WHI) and in the start cycle.
REQ-028 Latency with a slave answering one cycle after start: accept at T, ci_start at T+1, done at T+2, cmd_ready at T+3; final pair to res_valid = 7 cycles.
REQ-029 cmd_valid outside IDLE SHALL NOT be accepted; res_ready outside OUT has no effect.
REQ-030 ci_dataa/ci_datab SHALL be 0 during n=3 and n=4 issues.
REQ-031 ci_clk_en SHALL be 1 in every cycle after reset release.

Reset
REQ-032 On reset: state IDLE, first flag 1, cmd_ready 0 (1 from first cycle after release), res_valid 0, res_err 0, res_data 0, ci_start 0, ci_n 0, ci_dataa 0, ci_datab 0, ci_clk_en 0, timeout counter 0.
REQ-033 Reset mid-operation SHALL abandon the in-flight transaction without emitting res_valid.

Configuration
REQ-034 Macro CIM_TIMEOUT_EN defined: counter runs in wait states; if TIMEOUT cycles pass without ci_done, the FSM goes to OUT with res_err=1 and res_data=0; a late ci_done is ignored.
REQ-035 CIM_TIMEOUT_EN undefined: wait indefinitely; res_err tied 0; no counter logic.

Verification
REQ-036 Single pair a=3, b=-4, last=1, slave echoes MAC -> ci_n sequence 1,3,4; res_data=64'hFFFFFFFFFFFFFFF4, res_err=0.
REQ-037 Three pairs (2,5),(7,-1),(0x7FFFFFFF,0x7FFFFFFF) -> ci_n 1,2,2,3,4; res_data=64'h3FFFFFFF00000004.
REQ-038 res_ready held 0 for 10 cycles in OUT -> res_valid and res_data stable; cmd_ready=0 throughout.
REQ-039 Spurious ci_done in IDLE and in a start cycle -> no state change, no capture.
REQ-040 With CIM_TIMEOUT_EN, TIMEOUT=16, slave never answers n=1 -> res_valid after 16 wait cycles, res_err=1, res_data=0; next vector starts with n=1.
REQ-041 Reset asserted in WLO -> all outputs at reset values next cycle; the following vector (1,1,last) yields res_data=1.
